// File: rtl/rrarb_pkg.sv
// Shared types and helpers for the round-robin 4-phase handshake arbiter.
// Holds the FSM state enum and the index-width helper.
package rrarb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    REL
  } state_t;

  // Index width for n channels; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rrarb_pick.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Ports: req (request vector), ptr (scan start), gnt (one-hot), idx (winner).
module rrarb_pick
  import rrarb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int IDXW = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter merging N_CH 4-phase req/ack channels onto one resource.
// Ports: clk, rst (sync, active-high), req_i/ack_o per channel, req_o/ack_i
// to the resource, gnt_idx_o, busy_o. Macro RRARB_STATS_EN adds per-channel
// saturating grant counters with cnt_sel_i, cnt_o, cnt_clr_i.
module rr_handshake_arbiter
  import rrarb_pkg::*;
#(
  parameter  int N_CH  = 4
`ifdef RRARB_STATS_EN
  ,
  parameter  int CNT_W = 16
`endif
  ,
  localparam int IDXW  = idx_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_i,
  output logic [N_CH-1:0] ack_o,
  output logic            req_o,
  input  logic            ack_i,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            busy_o
`ifdef RRARB_STATS_EN
  ,
  input  logic [IDXW-1:0] cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic            cnt_clr_i
`endif
);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] win;
  logic [N_CH-1:0] win_oh;
  logic [N_CH-1:0] pick_oh;
  logic [IDXW-1:0] pick_idx;

  rrarb_pick #(
    .N_CH(N_CH)
  ) u_pick (
    .req(req_i),
    .ptr(ptr),
    .gnt(pick_oh),
    .idx(pick_idx)
  );

  assign gnt_idx_o = win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      win_oh <= '0;
      req_o  <= 1'b0;
      ack_o  <= '0;
      busy_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            win    <= pick_idx;
            win_oh <= pick_oh;
            req_o  <= 1'b1;
            busy_o <= 1'b1;
            state  <= REQ;
          end
        end
        // Winner is committed: its own req drop is ignored here.
        REQ: begin
          if (ack_i) begin
            ack_o <= win_oh;
            state <= ACK;
          end
        end
        ACK: begin
          if ((req_i & win_oh) == '0) begin
            req_o <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          if (!ack_i) begin
            ack_o  <= '0;
            busy_o <= 1'b0;
            ptr    <= (win == IDXW'(N_CH - 1)) ? '0 : win + 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef RRARB_STATS_EN
  logic [CNT_W-1:0] cnt [N_CH];
  logic             sel_ok;

  assign sel_ok = (32'(cnt_sel_i) < N_CH);

  // Clear wins over a same-cycle increment; counts saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (state == REQ && ack_i && cnt[win] != '1) begin
      cnt[win] <= cnt[win] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_o <= '0;
    else     cnt_o <= sel_ok ? cnt[cnt_sel_i] : '0;
  end
`endif

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Self-checking bench for rr_handshake_arbiter with N_CH=4.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_rr_handshake_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] ack_o;
  logic       req_o;
  logic       ack_i;
  logic [1:0] gnt_idx_o;
  logic       busy_o;
`ifdef RRARB_STATS_EN
  logic [1:0] cnt_sel_i;
  logic [1:0] cnt_o;
  logic       cnt_clr_i;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_handshake_arbiter #(
    .N_CH(4)
`ifdef RRARB_STATS_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .ack_o(ack_o),
    .req_o(req_o),
    .ack_i(ack_i),
    .gnt_idx_o(gnt_idx_o),
    .busy_o(busy_o)
`ifdef RRARB_STATS_EN
    ,
    .cnt_sel_i(cnt_sel_i),
    .cnt_o(cnt_o),
    .cnt_clr_i(cnt_clr_i)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       ereq;
    logic [3:0] eack;
    logic       ebusy;
    logic [1:0] egnt;
  } vec_t;

  localparam int NV = 24;
  vec_t v [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cond(input int w);
    case (w)
      0:       return req_o == 1'b1;
      1:       return ack_o != 4'h0;
      2:       return req_o == 1'b0;
      default: return busy_o == 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name);
    int n;
    n = 0;
    while (!cond(w) && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(cond(w)), 32'd1);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = 4'h0;
    ack_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One complete 4-phase handshake for the expected winner w.
  task automatic hs(input logic [3:0] reqv, input int w);
    logic [3:0] oh;
    oh    = 4'(1 << w);
    req_i = reqv;
    wait_for(0, "hs_req_o_rise");
    chk("hs_gnt", 32'(gnt_idx_o), 32'(w));
    ack_i = 1'b1;
    wait_for(1, "hs_ack_o_rise");
    chk("hs_ack_onehot", 32'(ack_o), 32'(oh));
    req_i = reqv & ~oh;
    wait_for(2, "hs_req_o_fall");
    ack_i = 1'b0;
    wait_for(3, "hs_busy_fall");
    chk("hs_ack_clear", 32'(ack_o), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    req_i = 4'h0;
    ack_i = 1'b0;
`ifdef RRARB_STATS_EN
    cnt_sel_i = 2'd0;
    cnt_clr_i = 1'b0;
`endif

    //        rst  req    ack  ereq eack  ebusy egnt
    v[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
    v[1]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
    v[2]  = '{1'b0, 4'h2, 1'b0, 1'b1, 4'h0, 1'b1, 2'd1};
    v[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd1};
    v[4]  = '{1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    v[5]  = '{1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    v[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1};
    v[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1};
    v[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
    v[9]  = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2};
    v[10] = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2};
    v[11] = '{1'b0, 4'hB, 1'b1, 1'b0, 4'h4, 1'b1, 2'd2};
    v[12] = '{1'b0, 4'hB, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
    v[13] = '{1'b0, 4'h9, 1'b0, 1'b1, 4'h0, 1'b1, 2'd3};
    v[14] = '{1'b0, 4'h9, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3};
    v[15] = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h8, 1'b1, 2'd3};
    v[16] = '{1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
    v[17] = '{1'b0, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 2'd0};
    v[18] = '{1'b0, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
    v[19] = '{1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
    v[20] = '{1'b0, 4'h4, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2};
    v[21] = '{1'b0, 4'h4, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2};
    v[22] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 2'd2};
    v[23] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};

    tick();
    for (int i = 0; i < NV; i++) begin
      rst   = v[i].rst;
      req_i = v[i].req;
      ack_i = v[i].ack;
      tick();
      chk($sformatf("vec%0d_req_o", i), 32'(req_o), 32'(v[i].ereq));
      chk($sformatf("vec%0d_ack_o", i), 32'(ack_o), 32'(v[i].eack));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(v[i].ebusy));
      if (v[i].ebusy || v[i].rst)
        chk($sformatf("vec%0d_gnt", i), 32'(gnt_idx_o), 32'(v[i].egnt));
    end

    // All channels requesting from reset: order 0,1,2,3,0.
    do_reset();
    hs(4'hF, 0);
    hs(4'hF, 1);
    hs(4'hF, 2);
    hs(4'hF, 3);
    hs(4'hF, 0);

    // Sole requester that just won wins again.
    hs(4'h2, 1);
    hs(4'h2, 1);

    // Late requester waits until channel 0 has fully released.
    do_reset();
    req_i = 4'h1;
    tick();
    chk("late_req_o", 32'(req_o), 32'd1);
    chk("late_gnt0", 32'(gnt_idx_o), 32'd0);
    req_i = 4'h3;
    tick();
    chk("late_wait_ack", 32'(ack_o), 32'd0);
    ack_i = 1'b1;
    tick();
    chk("late_ack0", 32'(ack_o), 32'h1);
    req_i = 4'h2;
    tick();
    chk("late_rel_req_o", 32'(req_o), 32'd0);
    chk("late_rel_ack", 32'(ack_o), 32'h1);
    ack_i = 1'b0;
    tick();
    chk("late_idle_ack", 32'(ack_o), 32'd0);
    chk("late_idle_busy", 32'(busy_o), 32'd0);
    tick();
    chk("late_ch1_req_o", 32'(req_o), 32'd1);
    chk("late_ch1_gnt", 32'(gnt_idx_o), 32'd1);
    chk("late_ch1_noack", 32'(ack_o), 32'd0);
    ack_i = 1'b1;
    tick();
    chk("late_ch1_ack", 32'(ack_o), 32'h2);
    req_i = 4'h0;
    tick();
    ack_i = 1'b0;
    tick();
    chk("late_end_busy", 32'(busy_o), 32'd0);

`ifdef RRARB_STATS_EN
    do_reset();
    cnt_sel_i = 2'd0;
    tick();
    chk("cnt_reset", 32'(cnt_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      hs(4'h1, 0);
      tick();
    end
    tick();
    chk("cnt_saturate", 32'(cnt_o), 32'd3);
    cnt_sel_i = 2'd1;
    tick();
    tick();
    chk("cnt_other_ch", 32'(cnt_o), 32'd0);
    cnt_sel_i = 2'd0;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    tick();
    chk("cnt_clear", 32'(cnt_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
